// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined single-precision adder.
// Holds the IEEE-754 field widths, the special constants, the packed
// operand view and the stage-1 special-case code.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = 24;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC00000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Special-value outcome decided in stage 1, applied in stage 2.
    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_NAN  = 2'd1,
        SP_INF  = 2'd2,
        SP_NEGZ = 2'd3
    } spec_e;

endpackage

// File: rtl/fp_add_pipelined_lzc24.sv
// Combinational 24-bit leading-zero counter.
// Ports:
//   vec_i  24-bit input vector
//   lz_o   number of leading zeros (24 when vec_i is all zero)
module lzc24 (
    input  logic [23:0] vec_i,
    output logic [4:0]  lz_o
);

    // Scan from the LSB upward; the last set bit seen is the most
    // significant one, so its position wins.
    always_comb begin
        lz_o = 5'd24;
        for (int unsigned i = 0; i < 24; i++) begin
            if (vec_i[i]) begin
                lz_o = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_pipelined.sv
// Two-stage pipelined IEEE-754 single-precision adder, truncating rounding.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   reg_A  operand A
//   reg_B  operand B
//   out    registered A+B, valid two clocks after the operands are sampled
module fp_add_pipelined
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] reg_A,
    input  logic [31:0] reg_B,
    output logic [31:0] out
);

    // ---------------- Stage 1: unpack, order, align, add ----------------
    fp32_t             a, b;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [SIG_W-1:0]  sig_a, sig_b, sig_big, sig_small, sig_shift;
    logic [EXP_W-1:0]  exp_big, exp_small, exp_diff;
    logic              sign_big, sign_small, a_is_big;

    logic              s1_sign_d, s1_sign_q;
    logic [EXP_W-1:0]  s1_exp_d, s1_exp_q;
    logic [SIG_W:0]    s1_sum_d, s1_sum_q;
    spec_e             s1_spec_d, s1_spec_q;
    logic              s1_inf_sign_d, s1_inf_sign_q;

    always_comb begin
        a = fp32_t'(reg_A);
        b = fp32_t'(reg_B);

        // Exponent 0 covers both true zero and denormals (flushed).
        a_zero = (a.exp == '0);
        b_zero = (b.exp == '0);
        a_inf  = (a.exp == EXP_MAX) && (a.frac == '0);
        b_inf  = (b.exp == EXP_MAX) && (b.frac == '0);
        a_nan  = (a.exp == EXP_MAX) && (a.frac != '0);
        b_nan  = (b.exp == EXP_MAX) && (b.frac != '0);

        sig_a = a_zero ? '0 : {1'b1, a.frac};
        sig_b = b_zero ? '0 : {1'b1, b.frac};

        a_is_big = ({a.exp, sig_a} >= {b.exp, sig_b});
        if (a_is_big) begin
            sign_big = a.sign; exp_big = a.exp; sig_big = sig_a;
            sign_small = b.sign; exp_small = b.exp; sig_small = sig_b;
        end else begin
            sign_big = b.sign; exp_big = b.exp; sig_big = sig_b;
            sign_small = a.sign; exp_small = a.exp; sig_small = sig_a;
        end

        exp_diff  = exp_big - exp_small;
        sig_shift = (exp_diff >= 8'd25) ? '0 : (sig_small >> exp_diff);

        s1_sign_d = sign_big;
        s1_exp_d  = exp_big;
        if (sign_big == sign_small) begin
            s1_sum_d = {1'b0, sig_big} + {1'b0, sig_shift};
        end else begin
            s1_sum_d = {1'b0, sig_big} - {1'b0, sig_shift};
        end

        s1_inf_sign_d = a_inf ? a.sign : b.sign;
        if (a_nan || b_nan || (a_inf && b_inf && (a.sign != b.sign))) begin
            s1_spec_d = SP_NAN;
        end else if (a_inf || b_inf) begin
            s1_spec_d = SP_INF;
        end else if (a_zero && b_zero && a.sign && b.sign) begin
            s1_spec_d = SP_NEGZ;
        end else begin
            s1_spec_d = SP_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_sign_q     <= 1'b0;
            s1_exp_q      <= '0;
            s1_sum_q      <= '0;
            s1_spec_q     <= SP_NONE;
            s1_inf_sign_q <= 1'b0;
        end else begin
            s1_sign_q     <= s1_sign_d;
            s1_exp_q      <= s1_exp_d;
            s1_sum_q      <= s1_sum_d;
            s1_spec_q     <= s1_spec_d;
            s1_inf_sign_q <= s1_inf_sign_d;
        end
    end

    // ---------------- Stage 2: normalize, pack, exceptions ----------------
    logic [4:0]          lz;
    logic [SIG_W-1:0]    sig_norm;
    logic signed [9:0]   exp_n;
    logic [31:0]         out_d, out_q;

    lzc24 u_lzc (
        .vec_i (s1_sum_q[SIG_W-1:0]),
        .lz_o  (lz)
    );

    always_comb begin
        if (s1_sum_q[SIG_W]) begin
            sig_norm = s1_sum_q[SIG_W:1];
            exp_n    = $signed({2'b00, s1_exp_q}) + 10'sd1;
        end else begin
            sig_norm = s1_sum_q[SIG_W-1:0] << lz;
            exp_n    = $signed({2'b00, s1_exp_q}) - $signed({5'b00000, lz});
        end

        unique case (s1_spec_q)
            SP_NAN:  out_d = QNAN;
            SP_INF:  out_d = {s1_inf_sign_q, EXP_MAX, {FRAC_W{1'b0}}};
            SP_NEGZ: out_d = 32'h80000000;
            default: begin
                if (s1_sum_q == '0) begin
                    out_d = 32'h00000000;
                end else if (exp_n >= 10'sd255) begin
                    out_d = {s1_sign_q, EXP_MAX, {FRAC_W{1'b0}}};
                end else if (exp_n <= 10'sd0) begin
                    out_d = {s1_sign_q, 31'b0};
                end else begin
                    out_d = {s1_sign_q, exp_n[EXP_W-1:0], sig_norm[FRAC_W-1:0]};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_fp_add_pipelined.sv
module tb_fp_add_pipelined;

    logic        clk;
    logic        reset;
    logic [31:0] reg_A;
    logic [31:0] reg_B;
    logic [31:0] out;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    fp_add_pipelined dut (
        .clk   (clk),
        .reset (reset),
        .reg_A (reg_A),
        .reg_B (reg_B),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    localparam int NV = 15;
    logic [31:0] va [NV] = '{
        32'h6b64b235, 32'h2ac49214, 32'h3f800000, 32'h3f800000, 32'h40400000,
        32'h7f800000, 32'h7f800000, 32'h7f7fffff, 32'h00000001, 32'h80000000,
        32'h7fc00000, 32'hff800000, 32'h00800000, 32'h3f800000, 32'h00000000};
    logic [31:0] vb [NV] = '{
        32'h6ac49214, 32'h6ac49214, 32'h33800000, 32'hbf800000, 32'hbf800000,
        32'hff800000, 32'h3f800000, 32'h7f7fffff, 32'h00000000, 32'h80000000,
        32'h3f800000, 32'hff800000, 32'h80800001, 32'h3f800000, 32'h80000000};
    logic [31:0] ve [NV] = '{
        32'h6ba37d9f, 32'h6ac49214, 32'h3f800000, 32'h00000000, 32'h40000000,
        32'h7fc00000, 32'h7f800000, 32'h7f800000, 32'h00000000, 32'h80000000,
        32'h7fc00000, 32'hff800000, 32'h80000000, 32'h40000000, 32'h00000000};

    initial begin
        reset = 1'b1;
        reg_A = 32'h3f800000;
        reg_B = 32'h3f800000;
        #2 reset = 1'b0;
        #1 check_eq("reset_async", out, 32'h0);
        repeat (2) @(posedge clk);
        #1 check_eq("reset_held", out, 32'h0);

        @(negedge clk);
        reset = 1'b1;

        // Back-to-back stream: vector k driven before edge k, checked after edge k+1.
        for (int cyc = 0; cyc < NV + 2; cyc++) begin
            @(negedge clk);
            if (cyc >= 2) check_eq($sformatf("vec%0d", cyc - 2), out, ve[cyc - 2]);
            if (cyc < NV) begin
                reg_A = va[cyc];
                reg_B = vb[cyc];
            end
        end

        // Exact two-clock latency on a fresh operand pair.
        @(negedge clk);
        reg_A = 32'h6b64b235;
        reg_B = 32'h6ac49214;
        @(posedge clk);
        #1 check_eq("lat_edge1_old", out, ve[NV - 1]);
        @(posedge clk);
        #1 check_eq("lat_edge2", out, 32'h6ba37d9f);

        // Reset between two valid inputs: in-flight result is dropped.
        @(negedge clk);
        reg_A = 32'h3f800000;
        reg_B = 32'h3f800000;
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check_eq("midrst_clear", out, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check_eq("midrst_edge1", out, 32'h0);
        @(posedge clk);
        #1 check_eq("midrst_edge2", out, 32'h40000000);
        @(posedge clk);
        #1 check_eq("const_hold", out, 32'h40000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
